pin_chain_tester: RTL and testbench



---
 rtl/pin_chain_pkg.sv | 27 ++
 rtl/pin_sync.sv | 31 +++
 rtl/pin_chain_tester.sv | 170 +++++++++++++++++
 tb/tb_pin_chain_tester.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pin_chain_pkg.sv
// Shared types and the chain test pattern table for the loopback pin-chain tester.
package pin_chain_pkg;

    localparam int N_PINS = 17;
    localparam int STEP_W = 6;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    // 0: zeros, 1..N: walking one, N+1: ones, N+2..2N+1: walking zero.
    function automatic logic [N_PINS-1:0] pattern(input logic [STEP_W-1:0] step);
        logic [N_PINS-1:0] one;
        int s;
        one = N_PINS'(1);
        s = int'(step);
        if (s == 0) return '0;
        if (s <= N_PINS) return one << (s - 1);
        if (s == N_PINS + 1) return '1;
        return ~(one << (s - N_PINS - 2));
    endfunction

endpackage

// File: rtl/pin_sync.sv
// Two-flop synchronizer for asynchronous inputs, synchronous active-high reset to 0.
module pin_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pin_chain_tester.sv
// Loopback pin-chain self-test: drives each pattern, waits for the synchronized
// echo to settle, accumulates a per-link fault mask and reports status on the RGB LED.
module pin_chain_tester
    import pin_chain_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              high_z,
    input  logic [N_PINS-1:0] chain_in,
    output logic [N_PINS-1:0] chain_out,
    output logic              drive_en,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              aborted,
    output logic [N_PINS-1:0] fail_mask,
    output logic              led_r,
    output logic              led_g,
    output logic              led_b
);

    localparam int CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP   = STEP_W'(2 * N_PINS + 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 2);

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_PINS-1:0]   chain_out_q, chain_out_d;
    logic                drive_en_q, drive_en_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                aborted_q, aborted_d;
    logic [N_PINS-1:0]   fail_mask_q, fail_mask_d;
    logic                start_prev_q, start_prev_d;

    logic [N_PINS-1:0]   sync_in;
    logic [0:0]          start_s;
    logic                start_edge;
    logic [N_PINS-1:0]   pat_cur;
    logic                run_next;

    pin_sync #(.WIDTH(N_PINS)) u_sync_in (
        .clk (clk),
        .rst (rst),
        .d   (chain_in),
        .q   (sync_in)
    );

    pin_sync #(.WIDTH(1)) u_sync_start (
        .clk (clk),
        .rst (rst),
        .d   (start),
        .q   (start_s)
    );

    assign start_edge = start_s[0] & ~start_prev_q;
    assign pat_cur    = pattern(step_q);

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        cnt_d        = cnt_q;
        done_d       = done_q;
        pass_d       = pass_q;
        aborted_d    = aborted_q;
        fail_mask_d  = fail_mask_q;
        start_prev_d = start_s[0];

        case (state_q)
            IDLE: begin
                if (start_edge && !high_z) begin
                    done_d      = 1'b0;
                    aborted_d   = 1'b0;
                    pass_d      = 1'b0;
                    fail_mask_d = '0;
                    step_d      = '0;
                    state_d     = APPLY;
                end
            end
            APPLY: begin
                cnt_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) state_d = CHECK;
                else                      cnt_d   = cnt_q + CNT_W'(1);
            end
            CHECK: begin
                fail_mask_d = fail_mask_q | (sync_in ^ pat_cur);
                if (step_q == LAST_STEP) begin
                    done_d  = 1'b1;
                    pass_d  = (fail_mask_d == '0);
                    state_d = DONE;
                end else begin
                    step_d  = step_q + STEP_W'(1);
                    state_d = APPLY;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Tristate request kills any run; the partial mask is kept for debug.
        if (high_z && state_q != IDLE) begin
            state_d   = IDLE;
            aborted_d = 1'b1;
            done_d    = 1'b0;
            pass_d    = pass_q;
        end

        // Pattern is registered so it reaches the pads together with the APPLY state.
        run_next    = (state_d == APPLY) || (state_d == SETTLE) || (state_d == CHECK);
        drive_en_d  = run_next;
        chain_out_d = run_next ? pattern(step_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            step_q       <= '0;
            cnt_q        <= '0;
            chain_out_q  <= '0;
            drive_en_q   <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            aborted_q    <= 1'b0;
            fail_mask_q  <= '0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            cnt_q        <= cnt_d;
            chain_out_q  <= chain_out_d;
            drive_en_q   <= drive_en_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            aborted_q    <= aborted_d;
            fail_mask_q  <= fail_mask_d;
            start_prev_q <= start_prev_d;
        end
    end

    always_comb begin
        led_r = 1'b0;
        led_g = 1'b0;
        led_b = 1'b0;
        if (aborted_q) begin
            led_r = 1'b1;
            led_g = 1'b1;
        end else if (busy) begin
            led_b = 1'b1;
        end else if (done_q) begin
            if (pass_q) led_g = 1'b1;
            else        led_r = 1'b1;
        end
    end

    assign busy      = (state_q == APPLY) || (state_q == SETTLE) || (state_q == CHECK);
    assign chain_out = chain_out_q;
    assign drive_en  = drive_en_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign aborted   = aborted_q;
    assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_pin_chain_tester.sv
// Scoreboarded bench: randomized link faults on the loopback, reference fault masks
// computed from the pattern rules, plus abort/reset/sample-point scenarios.
module tb_pin_chain_tester;
    import pin_chain_pkg::*;

    localparam int RUN_LEN = (2 * N_PINS + 2) * 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, high_z = 1'b0;
    logic [N_PINS-1:0] chain_in, chain_out, fail_mask;
    logic drive_en, busy, done, pass, aborted, led_r, led_g, led_b;

    logic start3 = 1'b0, high_z3 = 1'b0;
    logic [N_PINS-1:0] chain_in3, chain_out3, fail_mask3;
    logic drive_en3, busy3, done3, pass3, aborted3, led_r3, led_g3, led_b3;

    int fkind = 0, fa = 0, fb = 0;
    int dsel = 1;
    logic [N_PINS-1:0] dl0 = '0, dl1 = '0, dl2 = '0;

    always #5 clk = ~clk;

    pin_chain_tester u_dut (
        .clk(clk), .rst(rst), .start(start), .high_z(high_z), .chain_in(chain_in),
        .chain_out(chain_out), .drive_en(drive_en), .busy(busy), .done(done), .pass(pass),
        .aborted(aborted), .fail_mask(fail_mask), .led_r(led_r), .led_g(led_g), .led_b(led_b)
    );

    pin_chain_tester #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .high_z(high_z3), .chain_in(chain_in3),
        .chain_out(chain_out3), .drive_en(drive_en3), .busy(busy3), .done(done3), .pass(pass3),
        .aborted(aborted3), .fail_mask(fail_mask3), .led_r(led_r3), .led_g(led_g3), .led_b(led_b3)
    );

    // kind 0 none, 1 stuck-at-0 on a, 2 stuck-at-1 on a, 3 a/b wired-OR bridge
    function automatic logic [N_PINS-1:0] apply_fault(input logic [N_PINS-1:0] p,
                                                      input int kind, input int a, input int b);
        logic [N_PINS-1:0] r;
        logic v;
        r = p;
        case (kind)
            1: r[a] = 1'b0;
            2: r[a] = 1'b1;
            3: begin v = p[a] | p[b]; r[a] = v; r[b] = v; end
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [N_PINS-1:0] ref_pat(input int s);
        logic [N_PINS-1:0] p;
        for (int i = 0; i < N_PINS; i++) begin
            if (s == 0)               p[i] = 1'b0;
            else if (s <= N_PINS)     p[i] = (i == s - 1);
            else if (s == N_PINS + 1) p[i] = 1'b1;
            else                      p[i] = (i != s - N_PINS - 2);
        end
        return p;
    endfunction

    function automatic logic [N_PINS-1:0] ref_mask(input int kind, input int a, input int b);
        logic [N_PINS-1:0] m, p;
        m = '0;
        for (int s = 0; s <= 2 * N_PINS + 1; s++) begin
            p = ref_pat(s);
            m |= p ^ apply_fault(p, kind, a, b);
        end
        return m;
    endfunction

    assign chain_in = drive_en ? apply_fault(chain_out, fkind, fa, fb) : '0;

    always @(posedge clk) begin
        dl0 <= drive_en3 ? chain_out3 : '0;
        dl1 <= dl0;
        dl2 <= dl1;
    end
    assign chain_in3 = (dsel == 3) ? dl2 : dl0;

    typedef struct packed {
        logic [N_PINS-1:0] mask;
        logic              pass;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every completed run is popped from the scoreboard and compared.
    int cyc = 0, busy_start = 0;
    logic busy_prev = 1'b0, done_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (busy && !busy_prev) busy_start = cyc;
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("mask", 32'(fail_mask), 32'(e.mask));
                chk("pass", {31'd0, pass}, {31'd0, e.pass});
                chk("led_done", {29'd0, led_r, led_g, led_b}, e.pass ? 32'd2 : 32'd4);
                chk("run_len", 32'(cyc - busy_start), 32'(RUN_LEN));
            end
        end
        busy_prev = busy;
        done_prev = done;
    end

    task automatic pulse_start(input int which);
        @(negedge clk);
        if (which == 0) start = 1'b1; else start3 = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic wait_busy(input int which);
        int n = 0;
        while (((which == 0) ? busy : busy3) !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("busy_seen", {31'd0, (which == 0) ? busy : busy3}, 32'd1);
    endtask

    task automatic wait_done(input int which);
        int n = 0;
        while (((which == 0) ? done : done3) !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", {31'd0, (which == 0) ? done : done3}, 32'd1);
    endtask

    task automatic run_scored(input int kind, input int a, input int b, input bit restart_mid);
        logic [N_PINS-1:0] m;
        fkind = kind; fa = a; fb = b;
        m = ref_mask(kind, a, b);
        exp_q.push_back('{mask: m, pass: (m == '0)});
        pulse_start(0);
        wait_busy(0);
        if (restart_mid) begin
            repeat (17) @(negedge clk);
            pulse_start(0);
        end
        wait_done(0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N_PINS-1:0] dmask;
        repeat (3) @(negedge clk);
        chk("rst_flags", {24'd0, drive_en, busy, done, pass, aborted, led_r, led_g, led_b}, 32'd0);
        chk("rst_chain_out", 32'(chain_out), 32'd0);
        chk("rst_mask", 32'(fail_mask), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_scored(0, 0, 0, 1'b0);
        chk("ideal_mask", 32'(fail_mask), 32'h0);
        chk("ideal_led", {29'd0, led_r, led_g, led_b}, 32'd2);

        run_scored(1, 5, 0, 1'b0);
        chk("stuck5_mask", 32'(fail_mask), 32'h20);
        chk("stuck5_led", {29'd0, led_r, led_g, led_b}, 32'd4);

        run_scored(3, 2, 3, 1'b0);
        chk("bridge23_mask", 32'(fail_mask), 32'hC);

        repeat (8) begin
            run_scored($urandom_range(0, 3), $urandom_range(0, N_PINS - 1),
                       $urandom_range(0, N_PINS - 1), 1'b0);
        end

        // second start edge mid-run must not disturb the run
        run_scored(0, 0, 0, 1'b1);

        // abort by high_z 50 cycles into a run
        fkind = 0;
        pulse_start(0);
        wait_busy(0);
        repeat (46) @(negedge clk);
        high_z = 1'b1;
        @(negedge clk);
        chk("abort_flags", {27'd0, drive_en, busy, done, aborted, pass}, 32'h2);
        chk("abort_chain_out", 32'(chain_out), 32'd0);
        chk("abort_led", {29'd0, led_r, led_g, led_b}, 32'd6);
        chk("abort_mask", 32'(fail_mask), 32'd0);
        pulse_start(0);
        repeat (6) @(negedge clk);
        chk("hz_idle_ignore", {29'd0, busy, drive_en, aborted}, 32'd1);
        high_z = 1'b0;
        repeat (3) @(negedge clk);
        run_scored(0, 0, 0, 1'b0);
        chk("after_abort_aborted", {31'd0, aborted}, 32'd0);

        // reset mid-run
        fkind = 2; fa = $urandom_range(0, N_PINS - 1);
        pulse_start(0);
        wait_busy(0);
        repeat (90) @(negedge clk);
        chk("pre_rst_mask_nz", {31'd0, fail_mask != '0}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_flags", {24'd0, drive_en, busy, done, pass, aborted, led_r, led_g, led_b}, 32'd0);
        chk("midrst_chain_out", 32'(chain_out), 32'd0);
        chk("midrst_mask", 32'(fail_mask), 32'd0);
        rst = 1'b0;
        fkind = 0;
        repeat (3) @(negedge clk);

        // sample point at SETTLE_CYCLES=3: one extra pad delay is tolerated, three are not
        dsel = 1;
        pulse_start(1);
        wait_busy(1);
        wait_done(1);
        chk("s3_d1_pass", {31'd0, pass3}, 32'd1);
        chk("s3_d1_mask", 32'(fail_mask3), 32'd0);
        repeat (3) @(negedge clk);

        dsel = 3;
        dmask = '0;
        for (int s = 1; s <= 2 * N_PINS + 1; s++) dmask |= ref_pat(s) ^ ref_pat(s - 1);
        pulse_start(1);
        wait_busy(1);
        wait_done(1);
        chk("s3_d3_pass", {31'd0, pass3}, 32'd0);
        chk("s3_d3_mask", 32'(fail_mask3), 32'(dmask));

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
